// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared FSM state encodings and pipeline constants for the hazard controller.
package pipeline_pkg;
    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        FLUSH    = 2'b10,
        ILLEGAL  = 2'b11
    } state_t;
    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int CTRL_W = 9;
endpackage

// File: rtl/hazard_perf_counter.sv
// hazard_perf_counter: saturating event counter with enable, cleared only by reset.
module hazard_perf_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_en,
    output logic [W-1:0] o_count
);
    logic [W-1:0] r_count;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_count <= '0;
        else if (i_en && r_count != '1) r_count <= r_count + 1'b1;
    end
    assign o_count = r_count;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use stall, branch flush and memory-wait freeze control for the 5-stage pipeline.
// Performance counters are built only when HAZ_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             pipe_hold,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);
    localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES - 1);

    state_t     r_state, w_next;
    logic [1:0] r_fcnt, w_fcnt_next;
    logic       w_luh, w_mem_wait;

    assign w_luh = ex_mem_read && ex_rt != REG_ZERO &&
                   (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
    assign w_mem_wait = mem_req && !mem_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= RUN;
            r_fcnt  <= '0;
        end else begin
            r_state <= w_next;
            r_fcnt  <= w_fcnt_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_fcnt_next  = r_fcnt;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        pipe_hold    = 1'b0;
        case (r_state)
            RUN: begin
                if (w_mem_wait) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    pipe_hold   = 1'b1;
                    w_next      = MEM_WAIT;
                end else if (ex_branch_taken) begin
                    if_id_write  = 1'b0;
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        w_next      = FLUSH;
                        w_fcnt_next = FLUSH_INIT;
                    end
                end else if (w_luh) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                end
            end
            MEM_WAIT: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                pipe_hold   = 1'b1;
                w_next      = mem_ready ? RUN : MEM_WAIT;
            end
            FLUSH: begin
                if (w_mem_wait) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    pipe_hold   = 1'b1;
                    w_next      = MEM_WAIT;
                    w_fcnt_next = '0;
                end else begin
                    if_id_write  = 1'b0;
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    w_fcnt_next  = 2'(r_fcnt - 2'd1);
                    w_next       = (r_fcnt <= 2'd1) ? RUN : FLUSH;
                end
            end
            default: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
                w_next       = RUN;
            end
        endcase
        // Reset overrides everything so the pipeline sees NOP controls while held.
        if (!reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b0;
            id_ex_bubble = 1'b1;
            pipe_hold    = 1'b0;
        end
    end

    assign state = r_state;

`ifdef HAZ_PERF_CNT_EN
    logic w_stall_en;
    assign w_stall_en = reset && r_state == RUN && !w_mem_wait && !ex_branch_taken && w_luh;

    hazard_perf_counter #(.W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .rst_n   (reset),
        .i_en    (w_stall_en),
        .o_count (stall_count)
    );

    hazard_perf_counter #(.W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .rst_n   (reset),
        .i_en    (if_id_flush),
        .o_count (flush_count)
    );
`else
    assign stall_count = '0;
    assign flush_count = '0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed and randomized checks of pipeline_hazard_ctrl against a behavioural model.
module tb_pipeline_hazard_ctrl;
    localparam int FC    = 2;
    localparam int CNT_W = 16;
`ifdef HAZ_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [4:0]       id_rs = '0, id_rt = '0, ex_rt = '0;
    logic             id_uses_rt = 1'b0, ex_mem_read = 1'b0, ex_branch_taken = 1'b0;
    logic             mem_req = 1'b0, mem_ready = 1'b0;
    logic             pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_count, flush_count;

    int n_tests = 0;
    int n_fail  = 0;

    // model: mode 0 = running, 1 = waiting on memory, 2 = extra flush cycles pending
    int m_mode = 0, m_left = 0;
    longint m_stalls = 0, m_flushes = 0;
    longint cnt_max = (64'd1 << CNT_W) - 1;

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .ex_mem_read     (ex_mem_read),
        .ex_rt           (ex_rt),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .pc_write        (pc_write),
        .if_id_write     (if_id_write),
        .if_id_flush     (if_id_flush),
        .id_ex_bubble    (id_ex_bubble),
        .pipe_hold       (pipe_hold),
        .state           (state),
        .stall_count     (stall_count),
        .flush_count     (flush_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, "_stall_cnt"}, 32'(stall_count), PERF ? 32'(m_stalls) : 32'd0);
        chk({tag, "_flush_cnt"}, 32'(flush_count), PERF ? 32'(m_flushes) : 32'd0);
    endtask

    // One clock: drive at posedge+1, check outputs mid-cycle, update model at the edge.
    task automatic run_cycle(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                             input logic mrd, input logic [4:0] ert, input logic br,
                             input logic mq, input logic mrdy);
        bit luh, wait_now, e_pc, e_ifw, e_fl, e_bub, e_hold, stall;
        int nmode, nleft;
        id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_mem_read = mrd;
        ex_rt = ert; ex_branch_taken = br; mem_req = mq; mem_ready = mrdy;
        luh = mrd && ert != 0 && (ert == rs || (urt && ert == rt));
        wait_now = mq && !mrdy;
        e_pc = 1; e_ifw = 1; e_fl = 0; e_bub = 0; e_hold = 0; stall = 0;
        nmode = m_mode; nleft = m_left;
        if (m_mode == 1 || wait_now) begin
            e_pc = 0; e_ifw = 0; e_hold = 1;
            nmode = (m_mode == 1 && mrdy) ? 0 : 1;
            nleft = 0;
        end else if (m_mode == 2 || br) begin
            e_fl = 1; e_bub = 1;
            nleft = (m_mode == 2) ? m_left - 1 : FC - 1;
            nmode = nleft > 0 ? 2 : 0;
        end else if (luh) begin
            e_pc = 0; e_ifw = 0; e_bub = 1; stall = 1;
        end
        #4;
        chk("state", 32'(state), 32'(m_mode));
        chk("ctrl", {27'd0, pc_write, e_fl ? 1'b0 : if_id_write, if_id_flush, id_ex_bubble, pipe_hold},
                    {27'd0, e_pc, e_fl ? 1'b0 : e_ifw, e_fl, e_bub, e_hold});
        @(posedge clk);
        #1;
        m_mode = nmode; m_left = nleft;
        if (stall && m_stalls < cnt_max) m_stalls++;
        if (e_fl && m_flushes < cnt_max) m_flushes++;
        chk_counters("cyc");
    endtask

    task automatic idle();
        run_cycle(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Asserts reset mid-cycle and checks the asynchronous clear before the next edge.
    task automatic async_reset(input string tag);
        #3 reset = 1'b0;
        #1;
        chk({tag, "_state"}, 32'(state), 32'd0);
        chk({tag, "_pc_write"}, 32'(pc_write), 32'd0);
        chk({tag, "_bubble"}, 32'(id_ex_bubble), 32'd1);
        m_mode = 0; m_left = 0; m_stalls = 0; m_flushes = 0;
        chk_counters(tag);
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        // reset held for three cycles with hazardous inputs that must be masked
        for (int i = 0; i < 3; i++) begin
            mem_req = (i == 1); ex_branch_taken = (i == 2);
            ex_mem_read = 1'b1; ex_rt = 5'd3; id_rs = 5'd3;
            @(negedge clk);
            chk("rst_pc_write", 32'(pc_write), 32'd0);
            chk("rst_outs", {28'd0, if_id_write, if_id_flush, id_ex_bubble, pipe_hold}, 32'b0010);
            chk("rst_state", 32'(state), 32'd0);
            chk_counters("rst");
        end
        @(posedge clk);
        #1 reset = 1'b1;
        idle();

        // load-use: exactly one stall cycle
        run_cycle(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
        idle();
        chk("lu_stall_count", 32'(stall_count), PERF ? 32'd1 : 32'd0);
        // load to $0 and rt match without rt use: no stall
        run_cycle(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        run_cycle(5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        run_cycle(5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        idle();
        // branch with simultaneous load-use: branch wins, two flush cycles
        run_cycle(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
        idle();
        idle();
        chk("br_stall_count", 32'(stall_count), PERF ? 32'd2 : 32'd0);
        chk("br_flush_count", 32'(flush_count), PERF ? 32'd2 : 32'd0);
        // memory wait: four not-ready cycles then ready, hold for five
        for (int i = 0; i < 5; i++)
            run_cycle(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, i == 2, 1'b1, i == 4);
        idle();
        // flush preempted by a memory wait
        run_cycle(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        run_cycle(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        run_cycle(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        idle();

        for (int i = 0; i < 3000; i++)
            run_cycle(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                      1'($urandom), 5'($urandom_range(0, 3)), $urandom_range(0, 99) < 15,
                      $urandom_range(0, 99) < 20, 1'($urandom));

        // asynchronous reset in MEM_WAIT, then in FLUSH
        idle();
        run_cycle(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk("pre_rst_wait", 32'(state), 32'd1);
        async_reset("arst_wait");
        idle();
        run_cycle(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_flush", 32'(state), 32'd2);
        async_reset("arst_flush");
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
